// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-chain sequencer.
package rx_pkg;

  // Width of frequency words and of the demodulator period parameter.
  localparam int unsigned FREQ_W = 32;

  // Default system clock in Hz (clk_200 domain).
  localparam int unsigned CLK_FREQ_DEFAULT = 200000000;

  // Sequencer states. The numeric encoding is visible on state_out.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEASURE = 3'd1,
    ST_DIVIDE  = 3'd2,
    ST_SYNC    = 3'd3,
    ST_DATA    = 3'd4,
    ST_ERROR   = 3'd5
  } rxState_t;

  // A measured frequency is usable only inside [lo, hi]. A value of 0
  // means "not available" and falls outside any legal range.
  function automatic logic inRange(input logic [FREQ_W-1:0] f,
                                   input logic [FREQ_W-1:0] lo,
                                   input logic [FREQ_W-1:0] hi);
    return (f >= lo) && (f <= hi);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock.
// The cycle that sees start loads the operands. W iterations follow,
// and done is a one-cycle pulse that arrives together with the final quotient.
// The caller must never pass a zero divisor.
module seq_divider
  import rx_pkg::*;
#(
  parameter int unsigned W = FREQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  remR;
  logic [W-1:0]  quoR;
  logic [W-1:0]  divR;
  logic [CW-1:0] iterCnt;
  logic          running;

  logic [W:0]    trial;
  logic [W-1:0]  diff;
  logic          fits;

  // Trial subtraction on the partial remainder with the next dividend bit shifted in.
  always_comb begin
    trial = {remR, quoR[W-1]};
    fits  = (trial >= {1'b0, divR});
    // The low W bits are exact whenever fits is set, because the
    // remainder is then smaller than the divisor.
    diff  = trial[W-1:0] - divR;
  end

  // Shift/subtract iteration. The quotient bits enter from the LSB of quoR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remR    <= '0;
      quoR    <= '0;
      divR    <= '0;
      iterCnt <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remR    <= '0;
        quoR    <= dividend;
        divR    <= divisor;
        iterCnt <= CW'(W);
        running <= 1'b1;
      end else if (running) begin
        remR    <= fits ? diff : trial[W-1:0];
        quoR    <= {quoR[W-2:0], fits};
        iterCnt <= iterCnt - CW'(1);
        if (iterCnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quoR;

endmodule

// File: rtl/rx_sequencer.sv
// Receive-chain controller. It acquires a stable frequency and derives the
// demodulator period from it. It then hunts for the preamble and sync bit
// and assembles NBITS-wide words, MSB first, from the demodulated bit stream.
//
// Bit interface: bit_valid is a one-cycle strobe qualifying bit_in. There is
// no back-pressure. Every strobe seen while the registered state is SYNC or
// DATA is consumed in that cycle. Strobes in any other state are dropped.
module rx_sequencer
  import rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int unsigned NBITS        = 12,
  parameter int unsigned MIN_FREQ     = 1000,
  parameter int unsigned MAX_FREQ     = 20000000,
  parameter int unsigned STABLE_CNT   = 4,
  parameter int unsigned MEAS_TIMEOUT = 1000000,
  parameter int unsigned PREAMBLE_MIN = 5,
  parameter int unsigned SYNC_TIMEOUT = 256,
  parameter int unsigned GAP_TIMEOUT  = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [31:0]       freq_in,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [31:0]       freq_param,
  output logic              param_valid,
  output logic              demod_en,
  output logic [NBITS-1:0]  data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              error,
  output logic [2:0]        state_out
);

  rxState_t            state;

  logic [FREQ_W-1:0]   freqLatched;
  logic [FREQ_W-1:0]   prevFreq;
  logic [31:0]         stableCnt;
  logic [31:0]         measCnt;
  logic [31:0]         zeroRun;
  logic [31:0]         syncCnt;
  logic [31:0]         gapCnt;
  logic [31:0]         bitCnt;
  logic [NBITS-1:0]    shiftReg;
  logic                divStart;

  logic [FREQ_W-1:0]   divQuot;
  logic                divDone;

  logic [31:0]         stableNext;
  logic [NBITS-1:0]    shiftNext;

  // Period divider: CLK_FREQ / latched frequency.
  seq_divider #(
    .W (FREQ_W)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (divStart),
    .dividend (FREQ_W'(CLK_FREQ)),
    .divisor  (freqLatched),
    .quotient (divQuot),
    .done     (divDone)
  );

  // Next stability count for the current frequency sample, and the word
  // register after shifting the current bit in at the LSB.
  always_comb begin
    stableNext = '0;
    if (inRange(freq_in, FREQ_W'(MIN_FREQ), FREQ_W'(MAX_FREQ))) begin
      stableNext = (freq_in == prevFreq) ? stableCnt + 32'd1 : 32'd1;
    end
    shiftNext = {shiftReg[NBITS-2:0], bit_in};
  end

  // Main sequencer. Every output is registered here. busy and error are
  // updated on each transition so they always agree with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      freqLatched <= '0;
      prevFreq    <= '0;
      stableCnt   <= '0;
      measCnt     <= '0;
      zeroRun     <= '0;
      syncCnt     <= '0;
      gapCnt      <= '0;
      bitCnt      <= '0;
      shiftReg    <= '0;
      divStart    <= 1'b0;
      freq_param  <= '0;
      param_valid <= 1'b0;
      demod_en    <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      divStart   <= 1'b0;
      data_valid <= 1'b0;

      if (abort) begin
        // Abort discards any partial word. data_out keeps the last completed word.
        state       <= ST_IDLE;
        freq_param  <= '0;
        param_valid <= 1'b0;
        demod_en    <= 1'b0;
        busy        <= 1'b0;
        error       <= 1'b0;
        stableCnt   <= '0;
        measCnt     <= '0;
        zeroRun     <= '0;
        syncCnt     <= '0;
        gapCnt      <= '0;
        bitCnt      <= '0;
        shiftReg    <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_ERROR: begin
            if (start) begin
              state     <= ST_MEASURE;
              busy      <= 1'b1;
              error     <= 1'b0;
              prevFreq  <= '0;
              stableCnt <= '0;
              measCnt   <= '0;
              zeroRun   <= '0;
              syncCnt   <= '0;
              gapCnt    <= '0;
              bitCnt    <= '0;
              shiftReg  <= '0;
            end
          end

          ST_MEASURE: begin
            prevFreq  <= freq_in;
            stableCnt <= stableNext;
            measCnt   <= measCnt + 32'd1;
            if (stableNext == STABLE_CNT) begin
              freqLatched <= freq_in;
              divStart    <= 1'b1;
              state       <= ST_DIVIDE;
            end else if (measCnt == MEAS_TIMEOUT - 1) begin
              state <= ST_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end

          ST_DIVIDE: begin
            // The quotient is at least 2 because MAX_FREQ <= CLK_FREQ/2.
            if (divDone) begin
              freq_param  <= divQuot - 32'd2;
              param_valid <= 1'b1;
              demod_en    <= 1'b1;
              zeroRun     <= '0;
              syncCnt     <= '0;
              state       <= ST_SYNC;
            end
          end

          ST_SYNC: begin
            if (bit_valid) begin
              syncCnt <= syncCnt + 32'd1;
              if (bit_in && (zeroRun >= PREAMBLE_MIN)) begin
                // The sync 1 is the first data bit (MSB) of the word.
                shiftReg <= {{(NBITS-1){1'b0}}, 1'b1};
                bitCnt   <= 32'd1;
                gapCnt   <= '0;
                state    <= ST_DATA;
              end else begin
                zeroRun <= bit_in ? 32'd0 : zeroRun + 32'd1;
                if (syncCnt == SYNC_TIMEOUT - 1) begin
                  state       <= ST_ERROR;
                  busy        <= 1'b0;
                  error       <= 1'b1;
                  demod_en    <= 1'b0;
                  param_valid <= 1'b0;
                end
              end
            end
          end

          ST_DATA: begin
            if (bit_valid) begin
              shiftReg <= shiftNext;
              gapCnt   <= '0;
              if (bitCnt == NBITS - 1) begin
                data_out   <= shiftNext;
                data_valid <= 1'b1;
                bitCnt     <= '0;
                if (!continuous) begin
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  demod_en    <= 1'b0;
                  param_valid <= 1'b0;
                end
              end else begin
                bitCnt <= bitCnt + 32'd1;
              end
            end else if (gapCnt == GAP_TIMEOUT - 1) begin
              // The bit stream has stalled. The partial word is dropped.
              state       <= ST_ERROR;
              busy        <= 1'b0;
              error       <= 1'b1;
              demod_en    <= 1'b0;
              param_valid <= 1'b0;
            end else begin
              gapCnt <= gapCnt + 32'd1;
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            error <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_out = state;

endmodule

// File: doc/rx_sequencer.md
Name: rx_sequencer

Overview:
Central controller for the VPPM/FSK receive chain. It sequences the three receiver phases:
- frequency acquisition, using the median frequency-detector output;
- demodulator period computation, param = CLK_FREQ/f − 2;
- preamble/sync hunt followed by word assembly from the demodulated bit stream.

It sits between the frequency detector/median stage and the demodulator. It drives the demodulator's enable and period parameter, and adds the reset/restart and error handling the receive path currently lacks.

Parameters:
CLK_FREQ, 200000000, system clock in Hz (clk_200 domain).
NBITS, 12, data bits per word, MSB first.
MIN_FREQ, 1000, lowest accepted measured frequency (Hz).
MAX_FREQ, 20000000, highest accepted frequency (Hz); must be ≤ CLK_FREQ/2.
STABLE_CNT, 4, consecutive identical in-range measurements required to lock.
MEAS_TIMEOUT, 1000000, clk cycles allowed in MEASURE before error.
PREAMBLE_MIN, 5, minimum consecutive 0 bits before sync.
SYNC_TIMEOUT, 256, bit strobes allowed in SYNC before error.
GAP_TIMEOUT, 65536, max clk cycles between bit strobes in DATA.

Ports:
clk  in  1  system clock, 200 MHz
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins acquisition from IDLE or ERROR
abort  in  1  synchronous return to IDLE from any state
continuous  in  1  1 = keep assembling words after the first
freq_in  in  32  median detected frequency in Hz; 0 = not available
bit_in  in  1  demodulated bit
bit_valid  in  1  one-cycle strobe qualifying bit_in
freq_param  out  32  demodulator period parameter
param_valid  out  1  freq_param is valid
demod_en  out  1  demodulator enable
data_out  out  NBITS  last completed word
data_valid  out  1  one-cycle strobe with data_out
busy  out  1  state ≠ IDLE and state ≠ ERROR
error  out  1  high while in ERROR
state_out  out  3  current state encoding

Behaviour:
- Reset is asynchronous and active-low. On reset all outputs are 0, the state is IDLE, and all counters are cleared. Reset asserted mid-operation aborts immediately with no partial word output.
- State encoding: IDLE=0, MEASURE=1, DIVIDE=2, SYNC=3, DATA=4, ERROR=5.
- Priority: abort > start. start is ignored in states other than IDLE and ERROR. abort drops demod_en and param_valid in the next cycle.
- IDLE: start → MEASURE. Clears the stability count, timeout counter and shift register.
- MEASURE: freq_in is sampled every cycle.
  - A sample that is in range [MIN_FREQ, MAX_FREQ] and equal to the previous sample increments the stable count.
  - A sample that is in range but different from the previous sample sets the count to 1.
  - A sample that is 0 or out of range sets the count to 0.
  - When count = STABLE_CNT, latch freq_in and go to DIVIDE.
  - After MEAS_TIMEOUT cycles in MEASURE → ERROR.
- DIVIDE: the divider sub-module computes CLK_FREQ / f_latched, integer quotient with truncation, in 32 cycles plus one start cycle.
  - On done: freq_param = quotient − 2. Then param_valid = 1, demod_en = 1, go to SYNC.
  - The quotient is ≥ 2 by the MAX_FREQ constraint, so no underflow is possible.
- SYNC: bit strobes are counted only while registered state = SYNC. A strobe arriving in the entry cycle of SYNC counts.
  - bit_in = 0 increments the zero run.
  - bit_in = 1 with zero run ≥ PREAMBLE_MIN is the sync event. That 1 is data bit NBITS−1; the bit count becomes 1; go to DATA.
  - bit_in = 1 with zero run < PREAMBLE_MIN resets the zero run.
  - SYNC_TIMEOUT strobes without a sync event → ERROR.
- DATA: each strobe shifts bit_in in at the LSB and increments the bit count.
  - When the NBITS-th bit arrives, data_out is updated and data_valid is pulsed in the following cycle.
  - If continuous = 1: the bit count resets and the block stays in DATA.
  - If continuous = 0: go to IDLE, with demod_en and param_valid deasserted.
  - The gap counter resets on every strobe. Reaching GAP_TIMEOUT → ERROR, and the partial word is discarded.
- ERROR: error = 1, demod_en = 0, param_valid = 0. freq_param holds its last value. start → MEASURE and clears error.
- Outputs are registered. data_out holds its value until the next completed word.

Decomposition:
- Package rx_pkg holds:
  - the state enum/localparams (3-bit);
  - the CLK_FREQ default;
  - the width constant for freq/param (32).
- One sub-module, seq_divider: an iterative 32-bit restoring divider.
  - Ports: clk, rst_n, start, dividend, divisor, quotient, done.
  - done is a one-cycle pulse.

Test Plan:
1. freq_in = 5000000 held; start → DIVIDE after 4 samples; then freq_param = 38, param_valid = 1, demod_en = 1, state_out = 3.
2. After case 1: strobe bits 0,0,0,0,0,1 then 0,1,0,1,0,1,0,1,0,1,0 → data_out = 12'hAAA, data_valid for 1 cycle, state_out = 0 (continuous = 0).
3. freq_in alternating 5000000/4000000 for MEAS_TIMEOUT cycles → error = 1, state_out = 5. Then start with a stable 10000000 → freq_param = 18.
4. Only 4 zeros, then a 1, then 300 alternating strobes in SYNC → ERROR after 256 strobes; data_valid never asserted.
5. continuous = 1: two back-to-back 12-bit words → two data_valid pulses 12 strobes apart. Then stop strobes → ERROR after 65536 cycles.
6. Assert abort mid-DATA, and separately rst_n = 0 mid-DIVIDE → IDLE, all outputs 0 (except data_out after abort), no data_valid.
